// File: rtl/clk_time_set_ctrl_pkg.sv
// clk_time_set_ctrl_pkg
// Shared definitions for the clock time-setting path: write/field address
// codes, per-field maximum values, the sequencer state encoding and small
// helpers for wrap-around arithmetic on a field.
package clk_time_set_ctrl_pkg;

  // Address codes shared by the core write port and the edit_field output.
  localparam logic [1:0] ADDR_SEC   = 2'b00;
  localparam logic [1:0] ADDR_MIN   = 2'b01;
  localparam logic [1:0] ADDR_HR    = 2'b10;
  localparam logic [1:0] FIELD_NONE = 2'b11;

  // Largest legal value for each field.
  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;
  localparam logic [5:0] MAX_HR  = 6'd23;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_SET_SEC = 3'd3,
    ST_WR_HR   = 3'd4,
    ST_WR_MIN  = 3'd5,
    ST_WR_SEC  = 3'd6
  } state_t;

  // Step up, wrapping from max back to 0.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max_v);
    return (v >= max_v) ? 6'd0 : v + 6'd1;
  endfunction

  // Step down, wrapping from 0 back to max.
  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max_v);
    return ((v == 6'd0) || (v > max_v)) ? max_v : v - 6'd1;
  endfunction

  // Values read from the core that are out of range start the edit at 0.
  function automatic logic [5:0] clamp_field(input logic [5:0] v, input logic [5:0] max_v);
    return (v > max_v) ? 6'd0 : v;
  endfunction

endpackage

// File: rtl/clk_time_set_ctrl_btn_sync_edge.sv
// btn_sync_edge
// Two-flop synchronizer for one debounced button level followed by a
// registered rising-edge detector. A level first sampled high at edge k
// produces a one-cycle pulse that is visible to logic clocked at edge k+3.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   btn    in  raw (debounced) button level
//   pulse  out one-cycle registered pulse on each rising edge of btn
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic [1:0] sync_q;
  logic       prev_q;

  // sync_q[1] is the metastability-safe copy; prev_q remembers its last
  // value so a rising edge can be flagged, and the flag itself is
  // registered so downstream logic sees a clean single-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      prev_q <= sync_q[1];
      pulse  <= sync_q[1] & ~prev_q;
    end
  end

endmodule

// File: rtl/clk_time_set_ctrl.sv
// clk_time_set_ctrl
// Button-driven time-setting sequencer for the real-time clock core. The
// mode button enters editing (freezing the core via hold) and steps through
// hours, minutes and seconds; inc/dec adjust the shadow copy of the field
// being edited. Leaving seconds commits all three fields to the core as
// three back-to-back single-cycle writes. Inactivity in an edit state for
// TIMEOUT_CYCLES cycles abandons the edit without writing.
// Ports:
//   clk, reset                  clock and asynchronous active-high reset
//   btn_mode, btn_inc, btn_dec  debounced button levels
//   cur_sec, cur_min, cur_hr    core's current time, binary
//   load, addrs, data_in        core write port (registered)
//   hold                        freezes core counting while high
//   edit_field                  field being edited, 11 when not editing
module clk_time_set_ctrl
  import clk_time_set_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [5:0] cur_sec,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_hr,
  output logic       load,
  output logic [1:0] addrs,
  output logic [5:0] data_in,
  output logic       hold,
  output logic [1:0] edit_field
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic mode_pulse;
  logic inc_pulse;
  logic dec_pulse;

  btn_sync_edge u_sync_mode (.clk(clk), .reset(reset), .btn(btn_mode), .pulse(mode_pulse));
  btn_sync_edge u_sync_inc  (.clk(clk), .reset(reset), .btn(btn_inc),  .pulse(inc_pulse));
  btn_sync_edge u_sync_dec  (.clk(clk), .reset(reset), .btn(btn_dec),  .pulse(dec_pulse));

  state_t           state_q, state_d;
  logic [5:0]       hr_q, hr_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_d;
  logic [1:0]       addrs_d;
  logic [5:0]       data_d;
  logic             hold_d;
  logic [1:0]       field_d;

  // A step only counts when it is the lone edge: inc together with dec
  // cancels out, and mode together with either takes precedence.
  logic step_inc;
  logic step_dec;
  logic any_edge;
  logic in_edit;
  logic timed_out;

  assign step_inc  = inc_pulse & ~dec_pulse & ~mode_pulse;
  assign step_dec  = dec_pulse & ~inc_pulse & ~mode_pulse;
  assign any_edge  = mode_pulse | inc_pulse | dec_pulse;
  assign in_edit   = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN) || (state_q == ST_SET_SEC);
  assign timed_out = (cnt_q + CNT_W'(1)) == TIMEOUT_VAL;

  // State, shadow and idle-counter registers, plus the registered outputs,
  // all loaded from the next-state values computed below.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hr_q       <= 6'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      cnt_q      <= '0;
      load       <= 1'b0;
      addrs      <= ADDR_SEC;
      data_in    <= 6'd0;
      hold       <= 1'b0;
      edit_field <= FIELD_NONE;
    end else begin
      state_q    <= state_d;
      hr_q       <= hr_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      cnt_q      <= cnt_d;
      load       <= load_d;
      addrs      <= addrs_d;
      data_in    <= data_d;
      hold       <= hold_d;
      edit_field <= field_d;
    end
  end

  // Next state and shadow values, then the idle timeout override, then the
  // output values decoded from the state being entered so every output is
  // registered and changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    hr_d    = hr_q;
    min_d   = min_q;
    sec_d   = sec_q;
    cnt_d   = '0;
    load_d  = 1'b0;
    addrs_d = ADDR_SEC;
    data_d  = 6'd0;
    hold_d  = 1'b0;
    field_d = FIELD_NONE;

    case (state_q)
      ST_IDLE: begin
        if (mode_pulse) begin
          hr_d    = clamp_field(cur_hr, MAX_HR);
          min_d   = clamp_field(cur_min, MAX_MIN);
          sec_d   = clamp_field(cur_sec, MAX_SEC);
          state_d = ST_SET_HR;
        end
      end
      ST_SET_HR: begin
        if (mode_pulse)    state_d = ST_SET_MIN;
        else if (step_inc) hr_d = wrap_inc(hr_q, MAX_HR);
        else if (step_dec) hr_d = wrap_dec(hr_q, MAX_HR);
      end
      ST_SET_MIN: begin
        if (mode_pulse)    state_d = ST_SET_SEC;
        else if (step_inc) min_d = wrap_inc(min_q, MAX_MIN);
        else if (step_dec) min_d = wrap_dec(min_q, MAX_MIN);
      end
      ST_SET_SEC: begin
        if (mode_pulse)    state_d = ST_WR_HR;
        else if (step_inc) sec_d = wrap_inc(sec_q, MAX_SEC);
        else if (step_dec) sec_d = wrap_dec(sec_q, MAX_SEC);
      end
      ST_WR_HR:  state_d = ST_WR_MIN;
      ST_WR_MIN: state_d = ST_WR_SEC;
      ST_WR_SEC: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // The idle counter runs only while editing; any edge restarts it, and
    // reaching the limit abandons the edit without writing anything.
    if (in_edit) begin
      if (any_edge)       cnt_d = '0;
      else if (timed_out) state_d = ST_IDLE;
      else                cnt_d = cnt_q + CNT_W'(1);
    end

    hold_d = (state_d != ST_IDLE);
    case (state_d)
      ST_SET_HR:  field_d = ADDR_HR;
      ST_SET_MIN: field_d = ADDR_MIN;
      ST_SET_SEC: field_d = ADDR_SEC;
      ST_WR_HR: begin
        load_d  = 1'b1;
        addrs_d = ADDR_HR;
        data_d  = hr_d;
      end
      ST_WR_MIN: begin
        load_d  = 1'b1;
        addrs_d = ADDR_MIN;
        data_d  = min_d;
      end
      ST_WR_SEC: begin
        load_d  = 1'b1;
        addrs_d = ADDR_SEC;
        data_d  = sec_d;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clk_time_set_ctrl.sv
// tb_clk_time_set_ctrl
// Self-checking bench for clk_time_set_ctrl: directed edit sequences,
// wrap-around, ignored button combinations, timeout abort, reset during a
// commit, and randomized edits checked against modular-arithmetic expectations.
module tb_clk_time_set_ctrl;

  localparam int TIMEOUT = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc, btn_dec;
  logic [5:0] cur_sec, cur_min, cur_hr;
  logic       load;
  logic [1:0] addrs;
  logic [5:0] data_in;
  logic       hold;
  logic [1:0] edit_field;

  int pass_count  = 0;
  int check_count = 0;
  int load_count  = 0;
  int cycle       = 0;

  clk_time_set_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hr(cur_hr),
    .load(load), .addrs(addrs), .data_in(data_in),
    .hold(hold), .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  // Posedge counter, read at negedges to measure latencies in cycles.
  always @(posedge clk) cycle++;

  // Every cycle with load high is one write to the core.
  always @(negedge clk) if (load === 1'b1) load_count++;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  // Hold the selected buttons for two cycles, release, then idle `gap` cycles.
  task automatic apply_stimulus(input logic m, input logic i, input logic d, input int gap);
    btn_mode = m; btn_inc = i; btn_dec = d;
    repeat (2) @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Expect three consecutive writes hr/min/sec, then hold low one cycle later.
  task automatic expect_commit(input string tag, input int hr, input int mn, input int sc);
    int found;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (load === 1'b1) begin found = 1; break; end
    end
    check_output({tag, "_load_seen"}, found, 1);
    if (found == 1) begin
      check_output({tag, "_addr_hr"}, addrs, 2);
      check_output({tag, "_data_hr"}, data_in, hr);
      check_output({tag, "_hold_wr"}, hold, 1);
      @(negedge clk);
      check_output({tag, "_load_min"}, load, 1);
      check_output({tag, "_addr_min"}, addrs, 1);
      check_output({tag, "_data_min"}, data_in, mn);
      @(negedge clk);
      check_output({tag, "_load_sec"}, load, 1);
      check_output({tag, "_addr_sec"}, addrs, 0);
      check_output({tag, "_data_sec"}, data_in, sc);
      @(negedge clk);
      check_output({tag, "_load_end"}, load, 0);
      check_output({tag, "_hold_end"}, hold, 0);
      check_output({tag, "_field_end"}, edit_field, 3);
    end
  endtask

  function automatic int clamp_ref(input int v, input int max_v);
    return (v > max_v) ? 0 : v;
  endfunction

  initial begin
    int snap, start, stop, found;
    int cur_v[3];
    int exp_v[3];
    int max_v[3];
    int fld_v[3];
    int ni, nd, np;

    max_v = '{23, 59, 59};
    fld_v = '{2, 1, 0};

    reset = 1'b1;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    cur_sec = 6'd0; cur_min = 6'd0; cur_hr = 6'd0;

    // Reset values while reset is held, then after 1000 idle cycles.
    #50;
    check_output("rst_load", load, 0);
    check_output("rst_addrs", addrs, 0);
    check_output("rst_data", data_in, 0);
    check_output("rst_hold", hold, 0);
    check_output("rst_field", edit_field, 3);
    #50;
    reset = 1'b0;
    repeat (1000) @(negedge clk);
    check_output("idle_loads", load_count, 0);
    check_output("idle_hold", hold, 0);
    check_output("idle_field", edit_field, 3);

    // 12:34:56 -> hours +2, minutes -1.
    cur_hr = 6'd12; cur_min = 6'd34; cur_sec = 6'd56;
    apply_stimulus(1, 0, 0, 4);
    check_output("d1_field_hr", edit_field, 2);
    check_output("d1_hold", hold, 1);
    apply_stimulus(0, 1, 0, 4);
    apply_stimulus(0, 1, 0, 4);
    apply_stimulus(1, 0, 0, 4);
    check_output("d1_field_min", edit_field, 1);
    apply_stimulus(0, 0, 1, 4);
    apply_stimulus(1, 0, 0, 4);
    check_output("d1_field_sec", edit_field, 0);
    snap = load_count;
    apply_stimulus(1, 0, 0, 0);
    expect_commit("d1", 14, 33, 56);
    check_output("d1_load_total", load_count - snap, 3);

    // Wrap in both directions.
    cur_hr = 6'd23; cur_min = 6'd59; cur_sec = 6'd0;
    apply_stimulus(1, 0, 0, 4);
    apply_stimulus(0, 1, 0, 4);
    apply_stimulus(1, 0, 0, 4);
    apply_stimulus(0, 1, 0, 4);
    apply_stimulus(1, 0, 0, 4);
    apply_stimulus(0, 0, 1, 4);
    apply_stimulus(1, 0, 0, 0);
    expect_commit("wrap", 0, 0, 59);

    // Out-of-range hour captured as 0; mode+inc and inc+dec leave values alone.
    cur_hr = 6'd40; cur_min = 6'd10; cur_sec = 6'd5;
    apply_stimulus(1, 0, 0, 4);
    apply_stimulus(1, 1, 0, 4);
    check_output("combo_mode_wins", edit_field, 1);
    apply_stimulus(0, 1, 1, 4);
    check_output("combo_still_min", edit_field, 1);
    apply_stimulus(1, 0, 0, 4);
    apply_stimulus(1, 0, 0, 0);
    expect_commit("combo", 0, 10, 5);

    // Randomized edits against modular arithmetic on the captured time.
    for (int it = 0; it < 6; it++) begin
      cur_v[0] = $urandom_range(0, 63);
      cur_v[1] = $urandom_range(0, 63);
      cur_v[2] = $urandom_range(0, 63);
      cur_hr = 6'(cur_v[0]); cur_min = 6'(cur_v[1]); cur_sec = 6'(cur_v[2]);
      apply_stimulus(1, 0, 0, 4);
      for (int f = 0; f < 3; f++) begin
        ni = $urandom_range(0, 3);
        nd = $urandom_range(0, 3);
        np = $urandom_range(0, 1);
        for (int k = 0; k < np; k++) apply_stimulus(0, 1, 1, 4);
        for (int k = 0; k < ni; k++) apply_stimulus(0, 1, 0, 4);
        for (int k = 0; k < nd; k++) apply_stimulus(0, 0, 1, 4);
        exp_v[f] = ((clamp_ref(cur_v[f], max_v[f]) + ni - nd) % (max_v[f] + 1) + max_v[f] + 1) % (max_v[f] + 1);
        check_output($sformatf("rnd%0d_field%0d", it, f), edit_field, fld_v[f]);
        if (f < 2) apply_stimulus(1, 0, 0, 4);
      end
      apply_stimulus(1, 0, 0, 0);
      expect_commit($sformatf("rnd%0d", it), exp_v[0], exp_v[1], exp_v[2]);
    end

    // Timeout in SET_MIN: hold falls TIMEOUT cycles after the last acted edge.
    cur_hr = 6'd1; cur_min = 6'd2; cur_sec = 6'd3;
    apply_stimulus(1, 0, 0, 4);
    btn_mode = 1'b1;
    start = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 1) btn_mode = 1'b0;
      if (edit_field === 2'b01) begin start = cycle; break; end
    end
    btn_mode = 1'b0;
    check_output("to_enter_min", (start >= 0), 1);
    snap = load_count;
    stop = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (hold === 1'b0) begin stop = cycle; break; end
    end
    check_output("to_latency", stop - start, TIMEOUT);
    check_output("to_field", edit_field, 3);
    check_output("to_no_loads", load_count - snap, 0);

    // Reset landing in the WR_MIN cycle stops the commit at two writes.
    cur_hr = 6'd7; cur_min = 6'd8; cur_sec = 6'd9;
    snap = load_count;
    apply_stimulus(1, 0, 0, 4);
    apply_stimulus(1, 0, 0, 4);
    apply_stimulus(1, 0, 0, 4);
    btn_mode = 1'b1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 1) btn_mode = 1'b0;
      if (load === 1'b1 && addrs === 2'b01) begin found = 1; break; end
    end
    btn_mode = 1'b0;
    check_output("rwr_min_seen", found, 1);
    #2 reset = 1'b1;
    #1;
    check_output("rwr_load", load, 0);
    check_output("rwr_hold", hold, 0);
    check_output("rwr_field", edit_field, 3);
    check_output("rwr_data", data_in, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_output("rwr_two_writes", load_count - snap, 2);
    check_output("rwr_hold_after", hold, 0);

    // Normal commit after that reset.
    cur_hr = 6'd5; cur_min = 6'd6; cur_sec = 6'd7;
    apply_stimulus(1, 0, 0, 4);
    apply_stimulus(1, 0, 0, 4);
    apply_stimulus(1, 0, 0, 4);
    apply_stimulus(1, 0, 0, 0);
    expect_commit("post_rst", 5, 6, 7);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
